// File: rtl/lamp_fpu_sqrt_pkg.sv
// Shared definitions for the lampFPU square-root unit: float field widths,
// exponent bias, canonical special-value encodings and the sqrt FSM states.
// Pure declarations; no logic, no timing, no flow control.
package lamp_fpu_sqrt_pkg;

    localparam int LAMP_FLOAT_S_DW = 1;
    localparam int LAMP_FLOAT_E_DW = 8;
    localparam int LAMP_FLOAT_F_DW = 7;

    localparam logic [LAMP_FLOAT_E_DW-1:0] LAMP_FLOAT_E_BIAS = 8'd127;

    // Radicand holds 1.fffffff aligned so that its integer root has
    // 10 bits: hidden bit, 7 fraction bits, guard and round.
    localparam int LAMP_SQRT_RAD_DW  = 20;
    localparam int LAMP_SQRT_ROOT_DW = 10;
    localparam int LAMP_SQRT_REM_DW  = 12;

    localparam logic [3:0] LAMP_SQRT_LAST_ITER = 4'd9;

    localparam logic [LAMP_FLOAT_E_DW-1:0] LAMP_QNAN_E = 8'hFF;
    localparam logic [LAMP_FLOAT_F_DW-1:0] LAMP_QNAN_F = 7'b1000000;
    localparam logic [LAMP_FLOAT_E_DW-1:0] LAMP_INF_E  = 8'hFF;
    localparam logic [LAMP_FLOAT_F_DW-1:0] LAMP_INF_F  = 7'b0000000;
    localparam logic [LAMP_FLOAT_E_DW-1:0] LAMP_ZERO_E = 8'h00;
    localparam logic [LAMP_FLOAT_F_DW-1:0] LAMP_ZERO_F = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } sqrt_state_t;

endpackage

// File: rtl/lamp_fpu_sqrt_round.sv
// Rounds the 8-bit root (hidden bit + 7 fraction bits) using guard/round/sticky.
// Latency: combinational. Backpressure: none.
// LAMPFPU_SQRT_RNE_EN selects round-to-nearest-even; otherwise truncation.
// Ports: mant_i root with hidden bit, g_i/r_i/s_i guard/round/sticky,
//        f_o rounded fraction, exp_inc_o set when rounding carries to 2.0.
module lamp_fpu_sqrt_round
    import lamp_fpu_sqrt_pkg::*;
(
    input  logic [LAMP_FLOAT_F_DW:0]   mant_i,
    input  logic                       g_i,
    input  logic                       r_i,
    input  logic                       s_i,
    output logic [LAMP_FLOAT_F_DW-1:0] f_o,
    output logic                       exp_inc_o
);

`ifdef LAMPFPU_SQRT_RNE_EN
    logic                       round_up;
    logic [LAMP_FLOAT_F_DW+1:0] sum;
    logic                       unused_hidden;

    always_comb begin
        // Above half, or exactly half with an odd lsb, rounds up.
        round_up  = g_i & (r_i | s_i | mant_i[0]);
        sum       = {1'b0, mant_i} + {{(LAMP_FLOAT_F_DW+1){1'b0}}, round_up};
        // A carry out leaves the low bits all zero, i.e. 1.0 at exponent+1.
        f_o       = sum[LAMP_FLOAT_F_DW-1:0];
        exp_inc_o = sum[LAMP_FLOAT_F_DW+1];
    end

    assign unused_hidden = sum[LAMP_FLOAT_F_DW];
`else
    logic unused_grs;

    assign f_o        = mant_i[LAMP_FLOAT_F_DW-1:0];
    assign exp_inc_o  = 1'b0;
    assign unused_grs = ^{mant_i[LAMP_FLOAT_F_DW], g_i, r_i, s_i};
`endif

endmodule

// File: rtl/lamp_fpu_sqrt.sv
// Multi-cycle restoring square root for the lampFPU 1/8/7 float format.
// Latency: 1 edge for special operands, 12 edges for normal ones (10 ITER + ROUND + DONE).
// Backpressure: none; doSqrt_i is only sampled in IDLE and ignored while busy.
// Ports: clk/rst (async active-high), doSqrt_i start level, unpacked operand
//        (sign, biased exponent, mantissa with hidden bit, class flags),
//        valid_o one-cycle pulse, s/e/f_res_o held until the next result.
// Build option: LAMPFPU_SQRT_RNE_EN enables round-to-nearest-even.
module lamp_fpu_sqrt
    import lamp_fpu_sqrt_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       doSqrt_i,
    input  logic                       signum_op_i,
    input  logic [LAMP_FLOAT_E_DW-1:0] extExp_op_i,
    input  logic [LAMP_FLOAT_F_DW:0]   extMant_op_i,
    input  logic                       isZero_op_i,
    input  logic                       isInf_op_i,
    input  logic                       isSNAN_op_i,
    input  logic                       isQNAN_op_i,
    output logic                       valid_o,
    output logic                       s_res_o,
    output logic [LAMP_FLOAT_E_DW-1:0] e_res_o,
    output logic [LAMP_FLOAT_F_DW-1:0] f_res_o
);

    sqrt_state_t                      state_q, state_d;
    logic [3:0]                       cnt_q, cnt_d;
    logic [LAMP_SQRT_RAD_DW-1:0]      rad_q, rad_d;
    logic [LAMP_SQRT_REM_DW-1:0]      rem_q, rem_d;
    logic [LAMP_SQRT_ROOT_DW-1:0]     root_q, root_d;
    logic [LAMP_FLOAT_S_DW-1:0]       sgn_q, sgn_d;
    logic [LAMP_FLOAT_E_DW-1:0]       exp_q, exp_d;
    logic [LAMP_FLOAT_F_DW-1:0]       frac_q, frac_d;
    logic                             s_res_q, s_res_d;
    logic [LAMP_FLOAT_E_DW-1:0]       e_res_q, e_res_d;
    logic [LAMP_FLOAT_F_DW-1:0]       f_res_q, f_res_d;
    logic                             valid_q, valid_d;

    logic [LAMP_SQRT_REM_DW+1:0]      rem_t;
    logic [LAMP_SQRT_REM_DW+1:0]      trial;
    logic [LAMP_SQRT_REM_DW+1:0]      diff;
    logic [LAMP_FLOAT_E_DW:0]         exp_sum;
    logic                             exp_odd;
    logic [LAMP_FLOAT_F_DW-1:0]       rnd_f;
    logic                             rnd_inc;
    logic                             unused_bits;

    lamp_fpu_sqrt_round u_round (
        .mant_i    (root_q[LAMP_SQRT_ROOT_DW-1:2]),
        .g_i       (root_q[1]),
        .r_i       (root_q[0]),
        .s_i       (|rem_q),
        .f_o       (rnd_f),
        .exp_inc_o (rnd_inc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        sgn_d   = sgn_q;
        exp_d   = exp_q;
        frac_d  = frac_q;
        s_res_d = s_res_q;
        e_res_d = e_res_q;
        f_res_d = f_res_q;
        valid_d = 1'b0;

        // One restoring step: bring down two radicand bits, try subtracting 4q+1.
        rem_t = {rem_q, rad_q[LAMP_SQRT_RAD_DW-1 -: 2]};
        trial = {2'b00, root_q, 2'b01};
        diff  = rem_t - trial;

        // Unbiased exponent is odd exactly when the biased one is even.
        // (e-127-odd)>>>1 + 127 simplifies to floor((e+127)/2).
        exp_odd = ~extExp_op_i[0];
        exp_sum = {1'b0, extExp_op_i} + {1'b0, LAMP_FLOAT_E_BIAS};

        unique case (state_q)
            IDLE: begin
                if (doSqrt_i) begin
                    cnt_d  = '0;
                    rem_d  = '0;
                    root_d = '0;
                    frac_d = '0;
                    sgn_d  = 1'b0;
                    exp_d  = exp_sum[LAMP_FLOAT_E_DW:1];
                    // Align 1.fffffff (or 2x that for odd exponents) so the
                    // 10-bit integer root carries hidden, fraction, guard, round.
                    rad_d  = exp_odd ? {extMant_op_i, 12'b0}
                                     : {1'b0, extMant_op_i, 11'b0};
                    state_d = ITER;
                    if (isSNAN_op_i || isQNAN_op_i) begin
                        exp_d   = LAMP_QNAN_E;
                        frac_d  = LAMP_QNAN_F;
                        state_d = DONE;
                    end else if (isZero_op_i || !extMant_op_i[LAMP_FLOAT_F_DW]) begin
                        // Denormals flush to a zero of the operand's sign.
                        sgn_d   = signum_op_i;
                        exp_d   = LAMP_ZERO_E;
                        frac_d  = LAMP_ZERO_F;
                        state_d = DONE;
                    end else if (signum_op_i) begin
                        exp_d   = LAMP_QNAN_E;
                        frac_d  = LAMP_QNAN_F;
                        state_d = DONE;
                    end else if (isInf_op_i) begin
                        exp_d   = LAMP_INF_E;
                        frac_d  = LAMP_INF_F;
                        state_d = DONE;
                    end
                end
            end
            ITER: begin
                if (rem_t >= trial) begin
                    rem_d  = diff[LAMP_SQRT_REM_DW-1:0];
                    root_d = {root_q[LAMP_SQRT_ROOT_DW-2:0], 1'b1};
                end else begin
                    rem_d  = rem_t[LAMP_SQRT_REM_DW-1:0];
                    root_d = {root_q[LAMP_SQRT_ROOT_DW-2:0], 1'b0};
                end
                rad_d = {rad_q[LAMP_SQRT_RAD_DW-3:0], 2'b00};
                if (cnt_q == LAMP_SQRT_LAST_ITER) begin
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ROUND: begin
                frac_d  = rnd_f;
                exp_d   = exp_q + {{(LAMP_FLOAT_E_DW-1){1'b0}}, rnd_inc};
                state_d = DONE;
            end
            DONE: begin
                s_res_d = sgn_q;
                e_res_d = exp_q;
                f_res_d = frac_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The remainder never exceeds 2q, so the top difference bits stay zero.
    assign unused_bits = ^{diff[LAMP_SQRT_REM_DW+1 -: 2], exp_sum[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            sgn_q   <= '0;
            exp_q   <= '0;
            frac_q  <= '0;
            s_res_q <= 1'b0;
            e_res_q <= '0;
            f_res_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            sgn_q   <= sgn_d;
            exp_q   <= exp_d;
            frac_q  <= frac_d;
            s_res_q <= s_res_d;
            e_res_q <= e_res_d;
            f_res_q <= f_res_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;
    assign s_res_o = s_res_q;
    assign e_res_o = e_res_q;
    assign f_res_o = f_res_q;

endmodule

// File: tb/tb_lamp_fpu_sqrt.sv
// Directed bench for lamp_fpu_sqrt with a result scoreboard.
// Expected results are pushed when an operation is started and popped on valid_o.
module tb_lamp_fpu_sqrt;

    typedef struct packed {
        logic       s;
        logic [7:0] e;
        logic [6:0] f;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       doSqrt_i = 1'b0;
    logic       signum_op_i = 1'b0;
    logic [7:0] extExp_op_i = '0;
    logic [7:0] extMant_op_i = '0;
    logic       isZero_op_i = 1'b0;
    logic       isInf_op_i = 1'b0;
    logic       isSNAN_op_i = 1'b0;
    logic       isQNAN_op_i = 1'b0;
    logic       valid_o;
    logic       s_res_o;
    logic [7:0] e_res_o;
    logic [6:0] f_res_o;

    int   checks = 0;
    int   errors = 0;
    res_t sb_q[$];

    lamp_fpu_sqrt dut (
        .clk          (clk),
        .rst          (rst),
        .doSqrt_i     (doSqrt_i),
        .signum_op_i  (signum_op_i),
        .extExp_op_i  (extExp_op_i),
        .extMant_op_i (extMant_op_i),
        .isZero_op_i  (isZero_op_i),
        .isInf_op_i   (isInf_op_i),
        .isSNAN_op_i  (isSNAN_op_i),
        .isQNAN_op_i  (isQNAN_op_i),
        .valid_o      (valid_o),
        .s_res_o      (s_res_o),
        .e_res_o      (e_res_o),
        .f_res_o      (f_res_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: integer square root of the aligned radicand, then rounding.
    function automatic res_t model(input logic [7:0] e, input logic [7:0] m);
        int    u;
        longint rad;
        longint q;
        longint rem;
        int    ex;
        int    fm;
        res_t  r;
        u = int'(e) - 127;
        if (u % 2 != 0) begin
            rad = longint'(m) << 12;
            u   = u - 1;
        end else begin
            rad = longint'(m) << 11;
        end
        q = 0;
        while ((q + 1) * (q + 1) <= rad) q++;
        rem = rad - q * q;
        ex  = u / 2 + 127;
        fm  = int'(q >> 2);
`ifdef LAMPFPU_SQRT_RNE_EN
        if (q[1] && (q[0] || rem != 0 || fm[0])) begin
            fm = fm + 1;
            if (fm == 256) begin
                fm = 128;
                ex = ex + 1;
            end
        end
`endif
        r.s = 1'b0;
        r.e = ex[7:0];
        r.f = fm[6:0];
        return r;
    endfunction

    // Present an operand for one capture edge, then scramble the inputs.
    task automatic drive(input logic s, input logic [7:0] e, input logic [7:0] m,
                         input logic z, input logic inf, input logic sn, input logic qn);
        signum_op_i  = s;
        extExp_op_i  = e;
        extMant_op_i = m;
        isZero_op_i  = z;
        isInf_op_i   = inf;
        isSNAN_op_i  = sn;
        isQNAN_op_i  = qn;
        doSqrt_i     = 1'b1;
        @(posedge clk);
        #1;
        doSqrt_i     = 1'b0;
        signum_op_i  = 1'($urandom);
        extExp_op_i  = 8'($urandom);
        extMant_op_i = 8'($urandom);
    endtask

    // Wait for valid_o, check latency and the scoreboard head, then the pulse width.
    task automatic wait_result(input string tag, input int exp_lat);
        int   lat;
        logic seen;
        res_t r;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid_o) seen = 1'b1;
        end
        check({tag, "_seen"}, 32'(seen), 32'(1));
        if (seen && sb_q.size() > 0) begin
            r = sb_q.pop_front();
            check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
            check({tag, "_s"}, 32'(s_res_o), 32'(r.s));
            check({tag, "_e"}, 32'(e_res_o), 32'(r.e));
            check({tag, "_f"}, 32'(f_res_o), 32'(r.f));
            @(posedge clk);
            #1;
            check({tag, "_pulse"}, 32'(valid_o), 32'(0));
        end
    endtask

    task automatic run(input string tag, input logic s, input logic [7:0] e, input logic [7:0] m,
                       input logic z, input logic inf, input logic sn, input logic qn,
                       input res_t expv, input int lat);
        sb_q.push_back(expv);
        drive(s, e, m, z, inf, sn, qn);
        wait_result(tag, lat);
    endtask

    initial begin
        res_t qnan;
        res_t r;
        int   n;
        int   nvalid;
        int   pulse_at[2];
        int   k;
        logic arm;
        logic [7:0] e;
        logic [7:0] m;

        qnan = '{s: 1'b0, e: 8'hFF, f: 7'b1000000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid_o), 32'(0));
        check("rst_s", 32'(s_res_o), 32'(0));
        check("rst_e", 32'(e_res_o), 32'(0));
        check("rst_f", 32'(f_res_o), 32'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Special operands, one edge latency
        run("snan", 1'b1, 8'hFF, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, qnan, 1);
        run("qnan", 1'b0, 8'hFF, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b1, qnan, 1);
        run("neg4", 1'b1, 8'h81, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, qnan, 1);
        run("negzero", 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, '{s: 1'b1, e: 8'h00, f: 7'h00}, 1);
        run("denorm", 1'b0, 8'h00, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0, '{s: 1'b0, e: 8'h00, f: 7'h00}, 1);
        run("posinf", 1'b0, 8'hFF, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, '{s: 1'b0, e: 8'hFF, f: 7'h00}, 1);
        run("neginf", 1'b1, 8'hFF, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, qnan, 1);

        // Normal operands, twelve edge latency
        run("four", 1'b0, 8'h81, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, '{s: 1'b0, e: 8'h80, f: 7'b0000000}, 12);
        run("two", 1'b0, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, '{s: 1'b0, e: 8'h7F, f: 7'b0110101}, 12);
        run("nine", 1'b0, 8'h82, 8'h90, 1'b0, 1'b0, 1'b0, 1'b0, '{s: 1'b0, e: 8'h80, f: 7'b1000000}, 12);
        run("nearfour", 1'b0, 8'h80, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, model(8'h80, 8'hFE), 12);
        run("minexp", 1'b0, 8'h01, 8'hB3, 1'b0, 1'b0, 1'b0, 1'b0, model(8'h01, 8'hB3), 12);
        run("maxexp", 1'b0, 8'hFE, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, model(8'hFE, 8'hFF), 12);
        for (int i = 0; i < 6; i++) begin
            e = 8'($urandom_range(1, 254));
            m = 8'h80 | 8'($urandom_range(0, 127));
            run("rand", 1'b0, e, m, 1'b0, 1'b0, 1'b0, 1'b0, model(e, m), 12);
        end

        // Back-to-back: doSqrt_i held through the IDLE cycle after DONE
        sb_q.push_back('{s: 1'b0, e: 8'h80, f: 7'b0000000});
        sb_q.push_back('{s: 1'b0, e: 8'h80, f: 7'b0000000});
        signum_op_i  = 1'b0;
        extExp_op_i  = 8'h81;
        extMant_op_i = 8'h80;
        isZero_op_i  = 1'b0;
        isInf_op_i   = 1'b0;
        isSNAN_op_i  = 1'b0;
        isQNAN_op_i  = 1'b0;
        doSqrt_i     = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        k = 0;
        arm = 1'b0;
        pulse_at[0] = -1;
        pulse_at[1] = -1;
        while (k < 2 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (arm) begin
                doSqrt_i = 1'b0;
                arm = 1'b0;
            end
            if (valid_o) begin
                pulse_at[k] = n;
                if (sb_q.size() > 0) begin
                    r = sb_q.pop_front();
                    check("b2b_e", 32'(e_res_o), 32'(r.e));
                    check("b2b_f", 32'(f_res_o), 32'(r.f));
                end
                if (k == 0) arm = 1'b1;
                k++;
            end
        end
        doSqrt_i = 1'b0;
        check("b2b_first", 32'(pulse_at[0]), 32'(12));
        check("b2b_spacing", 32'(pulse_at[1] - pulse_at[0]), 32'(13));
        repeat (3) @(posedge clk);
        #1;

        // Reset while iterating aborts the operation
        drive(1'b0, 8'h82, 8'h90, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_valid", 32'(valid_o), 32'(0));
        check("abort_e", 32'(e_res_o), 32'(0));
        check("abort_f", 32'(f_res_o), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (valid_o) nvalid++;
        end
        check("abort_nopulse", 32'(nvalid), 32'(0));
        run("after_abort", 1'b0, 8'h82, 8'h90, 1'b0, 1'b0, 1'b0, 1'b0, '{s: 1'b0, e: 8'h80, f: 7'b1000000}, 12);

        check("sb_empty", 32'(sb_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lamp_fpu_sqrt.md
Name: lamp_fpu_sqrt

Overview:
Multi-cycle square-root unit for the lampFPU 16-bit float format: 1 sign bit, 8-bit exponent with bias 127, and 7-bit fraction.
- Takes an already-unpacked operand plus classification flags.
- Computes the root iteratively, digit by digit.
- Returns a packed sign/exponent/fraction result with a single-cycle valid pulse.
- Sits beside the add/mul/div units behind the FPU operand unpacker.

Parameters:
None. All widths come from lampFPU_pkg: LAMP_FLOAT_S_DW=1, LAMP_FLOAT_E_DW=8, LAMP_FLOAT_F_DW=7.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
doSqrt_i  in  1  start request (level); sampled only in IDLE
signum_op_i  in  1  operand sign
extExp_op_i  in  8  operand biased exponent
extMant_op_i  in  8  operand mantissa with explicit hidden bit in [7]
isZero_op_i  in  1  operand is ±0
isInf_op_i  in  1  operand is ±inf
isSNAN_op_i  in  1  operand is signalling NaN
isQNAN_op_i  in  1  operand is quiet NaN
valid_o  out  1  one-cycle result-valid pulse
s_res_o  out  1  result sign
e_res_o  out  8  result biased exponent
f_res_o  out  7  result fraction, hidden bit dropped

Behaviour:
- Reset: state goes to IDLE. valid_o=0, s_res_o=0, e_res_o=0, f_res_o=0, and all internal registers are cleared. Reset mid-operation aborts the operation with no valid pulse.
- FSM states: IDLE, ITER, ROUND, DONE.
- IDLE, doSqrt_i=1 at a clock edge: operands are captured at that edge.
  - Special operand → go to DONE with the special result.
  - Otherwise → go to ITER.
- Special-case priority, highest first:
  - SNAN or QNAN → canonical QNAN: s=0, e=0xFF, f=7'b1000000.
  - Zero, or hidden bit 0 (denormals are treated as zero) → signed zero: s=signum, e=0, f=0.
  - Negative non-zero (including -inf) → canonical QNAN.
  - +inf → s=0, e=0xFF, f=0.
- Normal path, exponent:
  - Unbiased exponent u = extExp - 127.
  - If u is odd: radicand = mant<<1 and u = u-1.
  - Result exponent = (u>>>1) + 127, arithmetic shift. The result never over- or underflows.
- Normal path, mantissa:
  - Radicand is zero-extended to 20 bits.
  - Restoring square root, one result bit per ITER cycle, 10 cycles. This yields 1.fffffff plus guard and round bits.
  - Sticky bit = final remainder ≠ 0.
- ROUND, one cycle: rounding per the Optional Feature. If rounding carries to 2.0, then exponent+1 and f=0.
- DONE, one cycle: valid_o=1 and results are registered, then go to IDLE.
- Latency, counted from the capturing edge:
  - Special case: valid_o is high after 1 edge.
  - Normal case: valid_o is high after 12 edges (10 ITER + ROUND + DONE).
- Output holding: s/e/f_res_o hold their value until the next DONE. valid_o is high for exactly one cycle.
- doSqrt_i while busy is ignored. If doSqrt_i is still high in the IDLE cycle after DONE, a new operation starts (back-to-back operation is allowed).
- Operand inputs need only be stable at the capture edge.
- s_res_o is always 0 for a non-zero result.

Optional Feature:
LAMPFPU_SQRT_RNE_EN
- Defined: round to nearest, ties to even, using guard, round and sticky.
- Undefined: truncate (guard/round/sticky are ignored). The ROUND state still exists, so latency is unchanged.

Decomposition:
- lampFPU_pkg: width constants, bias 127, canonical QNAN/INF/ZERO constants, and the sqrt FSM state enum.
- One natural sub-module, lamp_fpu_sqrt_round: combinational, takes {mant, g, r, s} and produces {f, exp_inc}. It hosts the LAMPFPU_SQRT_RNE_EN switch.

Test Plan:
- SNAN input (s=1, e=0xFF, mant=0x7F, isSNAN=1) → valid after 1 edge; s=0, e=0xFF, f=1000000.
- 4.0 (s=0, e=0x81, mant=0x80) → valid after 12 edges; s=0, e=0x80, f=0000000.
- 2.0 (e=0x80, mant=0x80) → s=0, e=0x7F, f=0110101, same with or without RNE.
- 9.0 (e=0x82, mant=0x90) → e=0x80, f=1000000. Also: -4.0 → QNAN; -0 → s=1, e=0, f=0; +inf → s=0, e=0xFF, f=0.
- Hold doSqrt_i=1 across two operations → two valid pulses, spaced 13 cycles apart for normal operands.
- Assert rst during ITER → outputs 0 immediately; no valid pulse; next start works normally.
